vote_tally_reader: RTL and testbench
====================================

Name: vote_tally_reader

Overview:
Result-readout master for the voting machine. It drives the machine's mode/button inputs in results mode and reads the led bus back for each of the four candidates. It captures the four tallies, then computes the total, the winner and a tie flag, and signals done. It sits between the voting machine and the result-reporting logic, replacing manual mode=1 button presses.

Parameters:
HOLD_CYCLES, 12, cycles each button is held in results mode; led sampled on the last held cycle; legal range 2..255.
GAP_CYCLES, 4, idle cycles with all buttons low between candidates; legal range 1..255.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  single-cycle request to read all tallies; honoured only in IDLE.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when results are valid.
results_valid  output  1  set with done; cleared on accepted start and on reset.
mode_o  output  1  drives the voting machine's mode; 1 = results display.
button1_o..button4_o  output  1 each  drive the voting machine's buttons; at most one high.
led_i  input  8  voting machine led bus (count of the pressed candidate).
tally1..tally4  output  8 each  captured count per candidate.
total  output  10  tally1+tally2+tally3+tally4, zero-extended, no overflow.
winner  output  2  index 0..3 of the maximum tally; lowest index wins on equal maxima.
tie  output  1  1 if two or more candidates share the maximum.
err  output  1  sample mismatch flag (optional feature); otherwise constant 0.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; all outputs 0, including tallies, total, winner, tie, err, mode_o and all buttons. Reset mid-read aborts immediately and releases all buttons.
- States: IDLE, PRESS, GAP, CALC, DONE. Internal idx is 2 bits and cnt is 8 bits.
- IDLE -> PRESS on clock edge with start=1. At that edge: idx=0, cnt=0, results_valid=0, err=0. Previous tallies are kept until overwritten.
- PRESS: mode_o=1 and button(idx+1)_o=1. cnt increments each cycle. On the edge where cnt==HOLD_CYCLES-1, tally(idx+1) is loaded from led_i, cnt is cleared and the state moves to GAP.
- GAP: mode_o=1, all buttons 0, for GAP_CYCLES cycles. Then if idx<3: idx++ and go to PRESS; else go to CALC with mode_o=0.
- CALC (1 cycle): mode_o=0. Registers total, winner and tie from the four tallies.
- DONE (1 cycle): done=1; results_valid set at entry; returns to IDLE.
- Latency: done is high in cycle 4*(HOLD_CYCLES+GAP_CYCLES)+2 after the start edge (66 with defaults).
- start while busy is ignored; no queueing.
- Buttons are never asserted with mode_o=0.
- All-zero tallies: winner=0, tie=1. All four at 255: total=1020.

Optional Feature:
DOUBLE_SAMPLE_EN
- Defined: led_i is also sampled at cnt==HOLD_CYCLES/2 (integer division). If that sample differs from the end-of-hold sample, err is set and held until the next accepted start or reset. The tally still takes the end-of-hold sample.
- Undefined: no mid-hold sample; err is tied to 0.

Decomposition:
- Package vote_pkg:
  - COUNT_W=8, NUM_CAND=4, TOTAL_W=10.
  - Typedef tally_t (logic [COUNT_W-1:0]).
  - Enum reader_state_e {IDLE, PRESS, GAP, CALC, DONE}.
- One sub-module, vote_winner_sel: combinational; four tally_t inputs; outputs winner[1:0] and tie. It is registered in CALC by the parent.

Test Plan:
- Against the real votingMachine in mode 0, cast 2 votes for button1, 1 for button2, 3 for button3, 0 for button4, then pulse start -> tally1..4=2,1,3,0; total=6; winner=2; tie=0; done at cycle 66; mode_o back to 0.
- Votes 4,4,1,0 -> winner=0, tie=1, total=9.
- No votes cast -> all tallies 0, total=0, winner=0, tie=1, results_valid=1.
- Pulse start again at cycle 20 of a read -> ignored; exactly one done pulse at cycle 66.
- Drive reset=0 while button2_o is high -> all outputs 0 asynchronously; after release, a fresh start gives correct tallies.
- With DOUBLE_SAMPLE_EN, a behavioural led model changes from 5 to 6 mid-hold for candidate 3 -> err=1, tally3=6. Without the macro -> err=0.

Source files
------------

// File: rtl/vote_tally_reader_pkg.sv
// Shared types and constants for the vote tally readout master.
package vote_pkg;

    localparam int COUNT_W  = 8;
    localparam int NUM_CAND = 4;
    localparam int TOTAL_W  = 10;

    typedef logic [COUNT_W-1:0] tally_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        GAP   = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4
    } reader_state_e;

    // One-hot button pattern for the candidate index being read.
    function automatic logic [NUM_CAND-1:0] button_onehot(input logic [1:0] idx);
        logic [NUM_CAND-1:0] oh;
        oh = 4'b0000;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/vote_tally_reader_if.sv
// Link between the readout master and the voting machine: mode, four
// buttons driven by the master, and the led count bus returned to it.
interface vote_tally_reader_if;

    logic                       mode_o;
    logic                       button1_o;
    logic                       button2_o;
    logic                       button3_o;
    logic                       button4_o;
    logic [vote_pkg::COUNT_W-1:0] led_i;

    modport master (
        output mode_o,
        output button1_o,
        output button2_o,
        output button3_o,
        output button4_o,
        input  led_i
    );

    modport slave (
        input  mode_o,
        input  button1_o,
        input  button2_o,
        input  button3_o,
        input  button4_o,
        output led_i
    );

endinterface

// File: rtl/vote_tally_reader_winner_sel.sv
// Combinational winner/tie selection over four tallies. Lowest index wins
// among equal maxima; tie flags two or more candidates on the maximum.
module vote_winner_sel
    import vote_pkg::*;
(
    input  tally_t      t0_i,
    input  tally_t      t1_i,
    input  tally_t      t2_i,
    input  tally_t      t3_i,
    output logic [1:0]  winner_o,
    output logic        tie_o
);

    tally_t     max_s;
    logic [2:0] nmax_s;

    // Strict greater-than keeps the earliest index on equal values.
    always_comb begin
        max_s    = t0_i;
        winner_o = 2'd0;
        if (t1_i > max_s) begin
            max_s    = t1_i;
            winner_o = 2'd1;
        end else begin
            max_s    = max_s;
        end
        if (t2_i > max_s) begin
            max_s    = t2_i;
            winner_o = 2'd2;
        end else begin
            max_s    = max_s;
        end
        if (t3_i > max_s) begin
            max_s    = t3_i;
            winner_o = 2'd3;
        end else begin
            max_s    = max_s;
        end
    end

    // Count how many candidates sit on the maximum.
    always_comb begin
        nmax_s = 3'd0;
        nmax_s = {2'b00, (t0_i == max_s)} + {2'b00, (t1_i == max_s)}
               + {2'b00, (t2_i == max_s)} + {2'b00, (t3_i == max_s)};
        tie_o  = (nmax_s >= 3'd2);
    end

endmodule

// File: rtl/vote_tally_reader.sv
// Result-readout master for the voting machine. Holds each candidate
// button in results mode, captures the led count, then registers total,
// winner and tie and pulses done.
// Optional build macro DOUBLE_SAMPLE_EN: adds a mid-hold led sample and
// raises err when it disagrees with the end-of-hold sample.
module vote_tally_reader
    import vote_pkg::*;
#(
    parameter int HOLD_CYCLES = 12,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 results_valid,
    vote_tally_reader_if.master  vm,
    output tally_t               tally1,
    output tally_t               tally2,
    output tally_t               tally3,
    output tally_t               tally4,
    output logic [TOTAL_W-1:0]   total,
    output logic [1:0]           winner,
    output logic                 tie,
    output logic                 err
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    reader_state_e         state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  load_s;
    logic                  clear_s;
    logic                  mode_q, mode_d;
    logic [NUM_CAND-1:0]   btn_q, btn_d;
    logic                  busy_q, done_q, valid_q;
    tally_t                tally_q [NUM_CAND];
    logic [TOTAL_W-1:0]    total_q;
    logic [1:0]            winner_q, win_s;
    logic                  tie_q, tie_s;
    logic                  err_q;

    // Next-state logic: hold/gap sequencing over the four candidates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRESS;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    load_s  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 8'd0;
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = PRESS;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CALC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Machine-side outputs follow the state being entered so they are registered.
    always_comb begin
        mode_d = (state_d == PRESS) || (state_d == GAP);
        if (state_d == PRESS) begin
            btn_d = button_onehot(idx_d);
        end else begin
            btn_d = 4'b0000;
        end
    end

    // State register and control outputs; reset aborts and releases buttons.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            mode_q  <= 1'b0;
            btn_q   <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            btn_q   <= btn_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (clear_s) begin
                valid_q <= 1'b0;
            end else if (state_d == DONE) begin
                valid_q <= 1'b1;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

    // Tally capture at end of hold; summary registered during CALC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally_q[i] <= '0;
            end
            total_q  <= '0;
            winner_q <= 2'd0;
            tie_q    <= 1'b0;
        end else begin
            if (load_s) begin
                tally_q[idx_q] <= vm.led_i;
            end else begin
                tally_q[idx_q] <= tally_q[idx_q];
            end
            if (state_q == CALC) begin
                total_q  <= TOTAL_W'(tally_q[0]) + TOTAL_W'(tally_q[1])
                          + TOTAL_W'(tally_q[2]) + TOTAL_W'(tally_q[3]);
                winner_q <= win_s;
                tie_q    <= tie_s;
            end else begin
                total_q  <= total_q;
                winner_q <= winner_q;
                tie_q    <= tie_q;
            end
        end
    end

`ifdef DOUBLE_SAMPLE_EN
    localparam logic [7:0] MID_CNT = 8'(HOLD_CYCLES / 2);

    tally_t mid_q;
    tally_t mid_s;

    // With a two-cycle hold the mid point is the last cycle, so use led directly.
    always_comb begin
        if (cnt_q == MID_CNT) begin
            mid_s = vm.led_i;
        end else begin
            mid_s = mid_q;
        end
    end

    // Mid-hold sample and sticky mismatch flag, cleared on accepted start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mid_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q == PRESS) && (cnt_q == MID_CNT)) begin
                mid_q <= vm.led_i;
            end else begin
                mid_q <= mid_q;
            end
            if (clear_s) begin
                err_q <= 1'b0;
            end else if (load_s && (mid_s != vm.led_i)) begin
                err_q <= 1'b1;
            end else begin
                err_q <= err_q;
            end
        end
    end
`else
    assign err_q = 1'b0;
`endif

    vote_winner_sel u_winner_sel (
        .t0_i     (tally_q[0]),
        .t1_i     (tally_q[1]),
        .t2_i     (tally_q[2]),
        .t3_i     (tally_q[3]),
        .winner_o (win_s),
        .tie_o    (tie_s)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign results_valid = valid_q;
    assign vm.mode_o     = mode_q;
    assign vm.button1_o  = btn_q[0];
    assign vm.button2_o  = btn_q[1];
    assign vm.button3_o  = btn_q[2];
    assign vm.button4_o  = btn_q[3];
    assign tally1        = tally_q[0];
    assign tally2        = tally_q[1];
    assign tally3        = tally_q[2];
    assign tally4        = tally_q[3];
    assign total         = total_q;
    assign winner        = winner_q;
    assign tie           = tie_q;
    assign err           = err_q;

endmodule

// File: tb/tb_vote_tally_reader.sv
// Bench for vote_tally_reader: behavioural voting-machine led model,
// table of vote patterns with a scoreboard queue, plus reset-abort sequence.
module tb_vote_tally_reader;
    import vote_pkg::*;

    typedef struct {
        int v[4];
        bit glitch;
        int t[4];
        int tot;
        int win;
        int tie;
        int err;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, results_valid, tie, err;
    tally_t tally1, tally2, tally3, tally4;
    logic [TOTAL_W-1:0] total;
    logic [1:0] winner;

    vote_tally_reader_if vm();

    vote_tally_reader #(.HOLD_CYCLES(12), .GAP_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .results_valid(results_valid), .vm(vm.master),
        .tally1(tally1), .tally2(tally2), .tally3(tally3), .tally4(tally4),
        .total(total), .winner(winner), .tie(tie), .err(err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    vec_t sb_q[$];
    vec_t vecs[8];

    logic [7:0] votes [4];
    bit glitch = 1'b0;
    int b3_cnt = 0;
    logic [7:0] led_s;

    // Count cycles button3 has been held, for the mid-hold led change.
    always @(posedge clock) begin
        if (vm.button3_o) b3_cnt <= b3_cnt + 1;
        else              b3_cnt <= 0;
    end

    // Behavioural voting machine in results mode.
    always_comb begin
        led_s = 8'd0;
        if (vm.mode_o) begin
            if (vm.button1_o)      led_s = votes[0];
            else if (vm.button2_o) led_s = votes[1];
            else if (vm.button3_o) led_s = (glitch && b3_cnt >= 9) ? 8'd6 : votes[2];
            else if (vm.button4_o) led_s = votes[3];
            else                   led_s = 8'd0;
        end
    end
    assign vm.led_i = led_s;

    // Button protocol monitor.
    always @(negedge clock) begin
        if (reset) begin
            if (!vm.mode_o && (vm.button1_o | vm.button2_o | vm.button3_o | vm.button4_o)) begin
                n_err++;
                $display("FAIL button_without_mode: got buttons %b with mode 0",
                         {vm.button4_o, vm.button3_o, vm.button2_o, vm.button1_o});
            end
            if ($countones({vm.button4_o, vm.button3_o, vm.button2_o, vm.button1_o}) > 1) begin
                n_err++;
                $display("FAIL button_onehot: got buttons %b, required at most one high",
                         {vm.button4_o, vm.button3_o, vm.button2_o, vm.button1_o});
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int out_bits_set();
        return $countones({busy, done, results_valid, vm.mode_o, vm.button1_o, vm.button2_o,
                           vm.button3_o, vm.button4_o, tally1, tally2, tally3, tally4,
                           total, winner, tie, err});
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input bit g, input int ta, input int tb, input int tc,
                                input int td, input int tot, input int win, input int ti,
                                input int e);
        vec_t r;
        r.v[0] = a; r.v[1] = b; r.v[2] = c; r.v[3] = d; r.glitch = g;
        r.t[0] = ta; r.t[1] = tb; r.t[2] = tc; r.t[3] = td;
        r.tot = tot; r.win = win; r.tie = ti; r.err = e;
        return r;
    endfunction

    // Full read: pushes expectation, pulses start, re-pulses start at cycle 20.
    task automatic run_read(input vec_t v);
        int first;
        int ndone;
        vec_t e;
        for (int i = 0; i < 4; i++) votes[i] = 8'(v.v[i]);
        glitch = v.glitch;
        sb_q.push_back(v);
        first = 0;
        ndone = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = c;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("tally1", int'(tally1), e.t[0]);
                    check("tally2", int'(tally2), e.t[1]);
                    check("tally3", int'(tally3), e.t[2]);
                    check("tally4", int'(tally4), e.t[3]);
                    check("total", int'(total), e.tot);
                    check("winner", int'(winner), e.win);
                    check("tie", int'(tie), e.tie);
                    check("results_valid", int'(results_valid), 1);
                    check("err", int'(err), e.err);
                end
            end
            if (c == 2) check("busy_during_read", int'(busy), 1);
            start = (c == 20) ? 1'b1 : 1'b0;
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        check("done_cycle", first, 66);
        check("done_count", ndone, 1);
        check("mode_after", int'(vm.mode_o), 0);
        check("busy_after", int'(busy), 0);
        check("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
        glitch = 1'b0;
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 4; i++) votes[i] = 8'd0;
        vecs[0] = mk(2, 1, 3, 0, 1'b0, 2, 1, 3, 0, 6, 2, 0, 0);
        vecs[1] = mk(4, 4, 1, 0, 1'b0, 4, 4, 1, 0, 9, 0, 1, 0);
        vecs[2] = mk(0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[3] = mk(255, 255, 255, 255, 1'b0, 255, 255, 255, 255, 1020, 0, 1, 0);
        vecs[4] = mk(7, 9, 9, 3, 1'b0, 7, 9, 9, 3, 28, 1, 1, 0);
        vecs[5] = mk(0, 0, 0, 1, 1'b0, 0, 0, 0, 1, 1, 3, 0, 0);
`ifdef DOUBLE_SAMPLE_EN
        vecs[6] = mk(1, 2, 5, 3, 1'b1, 1, 2, 6, 3, 12, 2, 0, 1);
`else
        vecs[6] = mk(1, 2, 5, 3, 1'b1, 1, 2, 6, 3, 12, 2, 0, 0);
`endif
        vecs[7] = mk(3, 0, 2, 1, 1'b0, 3, 0, 2, 1, 6, 0, 0, 0);

        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs_zero", out_bits_set(), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int k = 0; k < 7; k++) run_read(vecs[k]);

        // Reset while candidate 2 is held aborts immediately.
        votes[0] = 8'd9; votes[1] = 8'd8; votes[2] = 8'd7; votes[3] = 8'd6;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        waited = 0;
        while (!vm.button2_o && waited < 100) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check("button2_reached", int'(vm.button2_o), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs_zero", out_bits_set(), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run_read(vecs[7]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
